muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle HI/LO unit for MULT, MULTU, DIV and DIVU. It sits in EX beside the single-cycle ALU and receives the same register operands. It runs a 32-iteration shift-add multiply or restoring divide on operand magnitudes, applies sign correction, and writes HI/LO. The pipeline stalls on `busy` and reads HI/LO for MFHI/MFLO.

## Interface
- `ITER`, 32: iteration count; fixed for 32-bit operands.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high; aborts any operation.
- `start`  in  1  launch request, sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  multiplicand / dividend.
- `b`  in  32  multiplier / divisor.
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; HI/LO updated in the same cycle.
- `div_zero`  out  1  last completed divide had `b == 0`.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE: on `start`, latch op, a and b, then go to PREP.
  - PREP: form magnitudes (|x| only for signed ops) and record result signs, then go to RUN.
  - RUN: ITER iterations, then go to FIX.
  - FIX: sign-correct, write HI/LO, then go to IDLE with `done` = 1.
- Multiply:
  - 64-bit shift-add on magnitudes.
  - Signed: negate the 64-bit product if a[31]^b[31].
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring division with a 33-bit trial subtract per iteration; quotient bit = no borrow.
  - Signed quotient sign = a[31]^b[31]; remainder sign = a[31]; all arithmetic is mod 2^32.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - `b == 0`, any divide op: LO = 0xFFFFFFFF and HI = a, with no sign fix. `div_zero` is set at FIX.
- `div_zero` clears on the next accepted `start`. Multiply ops leave it at 0.
- `start` while busy is ignored; no queueing.
- `mthi`/`mtlo` while busy are ignored.
- In IDLE, `start` takes priority over `mthi`/`mtlo` in the same cycle; the MTHI/MTLO write is dropped.
- `mthi` and `mtlo` together write both registers.
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_zero` = 0, state = IDLE.

## Timing
- Cycle 0 is the cycle `start` is sampled.
  - `busy` is high in cycles 1–34.
  - FIX is cycle 34.
  - `done` is high in cycle 35, with new HI/LO visible in cycle 35.
  - A new `start` is accepted in cycle 35.
- MTHI/MTLO: the register updates at the edge ending the request cycle; one-cycle latency.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. No `done` is ever produced for the aborted op.
- `done` never coincides with `busy`.

## Configuration
- `MULDIV_DIV0_FAST_EN` defined:
  - A divide with `b == 0` goes PREP → FIX, skipping RUN.
  - `busy` is high in cycles 1–2 and `done` in cycle 3.
  - Results are identical to the slow path.
- Undefined: a zero-divisor divide runs all 32 iterations (`done` in cycle 35). The results are forced in FIX as specified above.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - state enum `muldiv_state_t` (IDLE, PREP, RUN, FIX);
  - `MULDIV_ITER` = 32;
  - the 6-bit iteration counter width.
- One sub-module, `div_step`, is combinational:
  - Inputs: 33-bit partial remainder and 32-bit divisor.
  - Outputs: next remainder and quotient bit.
  - The top level instantiates it once.
- The multiply path stays inline.

## Test plan
- MULT a = 0xFFFFFFFF, b = 2 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. `done` exactly in cycle 35, `busy` high cycles 1–34.
- MULTU a = 0xFFFFFFFF, b = 2 → HI = 0x00000001, LO = 0xFFFFFFFE. DIV a = 0xFFFFFFF9 (−7), b = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV a = 0x80000000, b = 0xFFFFFFFF → LO = 0x80000000, HI = 0, `div_zero` = 0.
- DIVU a = 7, b = 0 → LO = 0xFFFFFFFF, HI = 7, `div_zero` = 1. `done` in cycle 3 with `MULDIV_DIV0_FAST_EN`, cycle 35 without.
- `reset` in cycle 10 of a MULTU → cycle 11 has `busy` = 0, HI = LO = 0, and no `done` follows. A `start` raised in cycle 20 of a busy op is ignored.
- `mthi` with `wdata` = 0x12345678 while busy → HI is unchanged. The same write in IDLE → HI = 0x12345678 next cycle. `start` plus `mtlo` in the same IDLE cycle → LO holds only the op result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings, state type and helpers for the multi-cycle HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int MULDIV_ITER  = 32;
  localparam int MULDIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

  function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] x);
    return neg ? (32'd0 - x) : x;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic neg, input logic [63:0] x);
    return neg ? (64'd0 - x) : x;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the shifted partial remainder.
module div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] div_i,
  output logic [31:0] rem_o,
  output logic        qbit_o
);

  logic [33:0] trial;
  logic        unused_trial_msb;

  // Bit 33 is the borrow; a kept result is always below the divisor, so bit 32 is zero.
  assign trial            = {1'b0, rem_i} - {2'b00, div_i};
  assign qbit_o           = ~trial[33];
  assign rem_o            = qbit_o ? trial[31:0] : rem_i[31:0];
  assign unused_trial_msb = trial[32];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MULDIV_DIV0_FAST_EN to let zero-divisor divides skip the iteration phase.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int ITER = MULDIV_ITER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MULDIV_CNT_W-1:0] LAST_CNT = MULDIV_CNT_W'(ITER - 1);

  muldiv_state_t           state_q;
  logic [1:0]              op_q;
  logic [31:0]             a_q;
  logic [31:0]             b_q;
  logic [31:0]             mag_q;
  logic [63:0]             acc_q;
  logic                    neg_lo_q;
  logic                    neg_hi_q;
  logic [MULDIV_CNT_W-1:0] cnt_q;
  logic [31:0]             hi_q;
  logic [31:0]             lo_q;
  logic                    done_q;
  logic                    dz_q;

  logic        is_div;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic [32:0] mul_sum;
  logic [63:0] mul_acc_d;
  logic [32:0] rem_in;
  logic [31:0] rem_nxt;
  logic        qbit;
  logic [63:0] div_acc_d;
  logic [63:0] acc_d;
  logic [63:0] prod_fix;

  assign is_div = op_q[1];
  assign a_neg  = ~op_q[0] & a_q[31];
  assign b_neg  = ~op_q[0] & b_q[31];
  assign b_zero = (b_q == 32'd0);

  // Both paths keep |a| in the low half of acc_q and |b| in mag_q.
  // Multiply: add |b| into the upper half when the low bit is set, then shift right.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
  assign mul_acc_d = {mul_sum, acc_q[31:1]};

  // Divide: remainder in the upper half, dividend shifting out / quotient shifting in below.
  assign rem_in    = {acc_q[63:32], acc_q[31]};
  assign div_acc_d = {rem_nxt, acc_q[30:0], qbit};
  assign acc_d     = is_div ? div_acc_d : mul_acc_d;
  assign prod_fix  = cond_neg64(neg_lo_q, acc_q);

  div_step u_div_step (
    .rem_i  (rem_in),
    .div_i  (mag_q),
    .rem_o  (rem_nxt),
    .qbit_o (qbit)
  );

  always_ff @(posedge clk) begin
    done_q <= 1'b0;
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            dz_q    <= 1'b0;
            state_q <= PREP;
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        PREP: begin
          mag_q    <= cond_neg32(b_neg, b_q);
          acc_q    <= {32'd0, cond_neg32(a_neg, a_q)};
          neg_lo_q <= a_neg ^ b_neg;
          neg_hi_q <= a_neg;
          cnt_q    <= '0;
`ifdef MULDIV_DIV0_FAST_EN
          state_q  <= (is_div && b_zero) ? FIX : RUN;
`else
          state_q  <= RUN;
`endif
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + MULDIV_CNT_W'(1);
          if (cnt_q == LAST_CNT) state_q <= FIX;
        end
        FIX: begin
          if (is_div && b_zero) begin
            hi_q <= a_q;
            lo_q <= 32'hFFFF_FFFF;
            dz_q <= 1'b1;
          end else if (is_div) begin
            hi_q <= cond_neg32(neg_hi_q, acc_q[63:32]);
            lo_q <= cond_neg32(neg_lo_q, acc_q[31:0]);
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: stimulus queues expected HI/LO/div_zero and done cycle.
module tb_muldiv_unit;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;
  localparam int LAT_FULL = 35;
`ifdef MULDIV_DIV0_FAST_EN
  localparam int LAT_DZ = 3;
`else
  localparam int LAT_DZ = 35;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic int lat_of(input logic [1:0] o, input logic [31:0] y);
    return (o[1] && y == 32'd0) ? LAT_DZ : LAT_FULL;
  endfunction

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input bit push);
    exp_t e;
    op = o; a = x; b = y; start = 1'b1;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dz = edz; e.cyc = cyc + lat_of(o, y);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 64 && busy; k++) @(negedge clk);
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        chk("done_cycle", cyc, e.cyc);
        chk("done_not_busy", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);

    // Signed multiply with busy window check over cycles 1..34.
    issue(MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1);
    nb = 0;
    for (int k = 1; k < LAT_FULL; k++) begin
      if (!busy) nb++;
      @(negedge clk);
    end
    chk("busy_window_lows", nb, 32'd0);
    chk("busy_after_window", {31'd0, busy}, 32'd0);

    // Issued in cycle 35 of the previous op: must be accepted.
    issue(MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1);
    wait_idle();
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1);
    wait_idle();
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1);
    wait_idle();
    issue(DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 1);
    wait_idle();

    // Next accepted start clears div_zero.
    issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1);
    chk("div_zero_cleared", {31'd0, div_zero}, 32'd0);
    wait_idle();
    issue(MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1);
    wait_idle();
    issue(DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1);
    wait_idle();

    // A start raised in cycle 20 of a busy op is ignored.
    issue(MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 1);
    repeat (19) @(negedge clk);
    op = DIVU; a = 32'd1; b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("ignored_start_no_op", {31'd0, busy}, 32'd0);

    // MTHI while busy is dropped.
    issue(MULT, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1);
    mthi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_busy_hi", hi, 32'd1);
    wait_idle();

    // MTHI in IDLE, then MTHI+MTLO together.
    mthi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_idle_hi", hi, 32'h1234_5678);
    chk("mthi_idle_lo", lo, 32'd15);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo_hi", hi, 32'hCAFE_F00D);
    chk("mthilo_lo", lo, 32'hCAFE_F00D);

    // start wins over MTLO in the same IDLE cycle.
    mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    issue(MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1);
    mtlo = 1'b0;
    chk("start_mtlo_lo", lo, 32'hCAFE_F00D);
    wait_idle();

    // Reset in cycle 10 aborts; no done may follow.
    @(negedge clk);
    issue(MULTU, 32'd5, 32'd6, 32'd0, 32'd0, 1'b0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (40) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
